// File: rtl/rf_wport_sched_pkg.sv
// rtl/rf_wport_sched_pkg.sv - shared constants, types and helpers for the write-port scheduler
package rf_wport_sched_pkg;

  localparam int RF_XLEN   = 32;
  localparam int REG_NUM   = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO
  } port_src_e;

  // x0 never gets a scoreboard bit, so it maps to an all-zero mask.
  function automatic logic [REG_NUM-1:0] rd_onehot(input logic [RF_ADDR_W-1:0] a);
    rd_onehot = '0;
    if (a != '0) rd_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with push/pop/full/empty/count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == (AW+1)'(DEPTH));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    rdata_o  = mem_q[rd_ptr_q];
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rf_wport_sched.sv
// rtl/rf_wport_sched.sv - shares the regfile write port between WB and a long-latency unit, with hazard scoreboard
module rf_wport_sched
  import rf_wport_sched_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_rd_addr_i,
  input  logic [XLEN-1:0]      wb_rd_data_i,
  input  logic                 mc_issue_i,
  input  logic [4:0]           mc_issue_rd_i,
  input  logic                 mc_valid_i,
  input  logic [4:0]           mc_rd_addr_i,
  input  logic [XLEN-1:0]      mc_data_i,
  output logic                 mc_ready_o,
  input  logic [4:0]           dec_rs1_addr_i,
  input  logic [4:0]           dec_rs2_addr_i,
  input  logic [4:0]           dec_rd_addr_i,
  output logic                 dec_stall_o,
  output logic                 wb_hold_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_rd_addr_o,
  output logic [XLEN-1:0]      rf_rd_data_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int EW = RF_ADDR_W + XLEN;

  logic [EW-1:0]        head;
  logic                 fifo_empty, fifo_full;
  logic [CW-1:0]        fifo_count;
  logic                 real_wb, push, pop;
  port_src_e            src;
  logic [RF_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]      head_data;
  logic [REG_NUM-1:0]   pending_q, pending_d;
  logic [REG_NUM-1:0]   pop_mask, pend_eff;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 hold_q, hold_d;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({mc_rd_addr_i, mc_data_i}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    head_rd      = head[EW-1:XLEN];
    head_data    = head[XLEN-1:0];
    real_wb      = wb_we_i && (wb_rd_addr_i != '0);
    mc_ready_o   = (fifo_count != CW'(FIFO_DEPTH));
    src          = SRC_NONE;
    if (!rst_i) begin
      if (real_wb)          src = SRC_WB;
      else if (!fifo_empty) src = SRC_FIFO;
    end
    pop          = (src == SRC_FIFO);
    push         = mc_valid_i && mc_ready_o && !rst_i;
    rf_we_o      = 1'b0;
    rf_rd_addr_o = '0;
    rf_rd_data_o = '0;
    case (src)
      SRC_WB: begin
        rf_we_o      = 1'b1;
        rf_rd_addr_o = wb_rd_addr_i;
        rf_rd_data_o = wb_rd_data_i;
      end
      SRC_FIFO: begin
        rf_we_o      = (head_rd != '0);
        rf_rd_addr_o = head_rd;
        rf_rd_data_o = head_data;
      end
      default: ;
    endcase

    // The regfile writes through, so a register retiring this cycle no longer blocks decode.
    pop_mask    = pop ? rd_onehot(head_rd) : '0;
    pend_eff    = pending_q & ~pop_mask & ~REG_NUM'(1);
    dec_stall_o = !rst_i && (pend_eff[dec_rs1_addr_i] || pend_eff[dec_rs2_addr_i] ||
                             pend_eff[dec_rd_addr_i]);

    // Clear first so a same-cycle reissue of the retiring rd keeps its bit.
    pending_d = pending_q & ~pop_mask;
    if (mc_issue_i) pending_d = pending_d | rd_onehot(mc_issue_rd_i);

    starve_d = starve_q;
    hold_d   = 1'b0;
    if (pop) begin
      starve_d = '0;
    end else if (!fifo_empty && real_wb) begin
      if (starve_q == SW'(STARVE_MAX - 1)) begin
        starve_d = '0;
        hold_d   = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
    wb_hold_o = hold_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      starve_q  <= '0;
      hold_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_rf_wport_sched.sv
// tb/tb_rf_wport_sched.sv - directed self-checking bench for rf_wport_sched
module tb_rf_wport_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_rd_data_i;
  logic        mc_issue_i;
  logic [4:0]  mc_issue_rd_i;
  logic        mc_valid_i;
  logic [4:0]  mc_rd_addr_i;
  logic [31:0] mc_data_i;
  logic        mc_ready_o;
  logic [4:0]  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
  logic        dec_stall_o, wb_hold_o, rf_we_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;

  int total = 0;
  int bad   = 0;

  rf_wport_sched #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wb_we_i        (wb_we_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .wb_rd_data_i   (wb_rd_data_i),
    .mc_issue_i     (mc_issue_i),
    .mc_issue_rd_i  (mc_issue_rd_i),
    .mc_valid_i     (mc_valid_i),
    .mc_rd_addr_i   (mc_rd_addr_i),
    .mc_data_i      (mc_data_i),
    .mc_ready_o     (mc_ready_o),
    .dec_rs1_addr_i (dec_rs1_addr_i),
    .dec_rs2_addr_i (dec_rs2_addr_i),
    .dec_rd_addr_i  (dec_rd_addr_i),
    .dec_stall_o    (dec_stall_o),
    .wb_hold_o      (wb_hold_o),
    .rf_we_o        (rf_we_o),
    .rf_rd_addr_o   (rf_rd_addr_o),
    .rf_rd_data_o   (rf_rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wb_we_i = 0; wb_rd_addr_i = 0; wb_rd_data_i = 0;
    mc_issue_i = 0; mc_issue_rd_i = 0;
    mc_valid_i = 0; mc_rd_addr_i = 0; mc_data_i = 0;
    dec_rs1_addr_i = 0; dec_rs2_addr_i = 0; dec_rd_addr_i = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1; wb_rd_addr_i = a; wb_rd_data_i = d;
  endtask

  task automatic mc(input logic [4:0] a, input logic [31:0] d);
    mc_valid_i = 1; mc_rd_addr_i = a; mc_data_i = d;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 64'(rf_we_o), 64'(we));
    if (we) begin
      chk({tag, "_addr"}, 64'(rf_rd_addr_o), 64'(a));
      chk({tag, "_data"}, 64'(rf_rd_data_o), 64'(d));
    end
  endtask

  // Protocol monitors on the stimulus side.
  logic        wait_q = 0;
  logic [4:0]  wait_addr;
  logic [31:0] wait_data;
  always @(negedge clk_i) begin
    logic [4:0] popping_rd;
    if (rst_i) begin
      wait_q = 0;
    end else begin
      popping_rd = (rf_we_o && !(wb_we_i && wb_rd_addr_i != 0)) ? rf_rd_addr_o : 5'd0;
      if (wb_we_i && wb_rd_addr_i != 0) begin
        total++;
        assert (dut.pending_q[wb_rd_addr_i] === 1'b0) else begin
          bad++;
          $error("FAIL proto_wb_to_pending observed=1 expected=0 rd=%0d", wb_rd_addr_i);
        end
      end
      if (mc_issue_i && mc_issue_rd_i != 0 && mc_issue_rd_i != popping_rd) begin
        total++;
        assert (dut.pending_q[mc_issue_rd_i] === 1'b0) else begin
          bad++;
          $error("FAIL proto_issue_to_pending observed=1 expected=0 rd=%0d", mc_issue_rd_i);
        end
      end
      if (wait_q) begin
        total++;
        assert (mc_valid_i && mc_rd_addr_i == wait_addr && mc_data_i == wait_data) else begin
          bad++;
          $error("FAIL proto_mc_stable observed=%0h expected=%0h", mc_data_i, wait_data);
        end
      end
      wait_q    = mc_valid_i && !mc_ready_o;
      wait_addr = mc_rd_addr_i;
      wait_data = mc_data_i;
    end
  end

  initial begin
    idle();
    rst_i = 1;
    wb(5'd3, 32'h3);
    #1;
    chk("rst_rf_we", 64'(rf_we_o), 64'd0);
    chk("rst_stall", 64'(dec_stall_o), 64'd0);
    tick(); tick();
    idle();
    rst_i = 0;
    #1;
    chk("rst_ready", 64'(mc_ready_o), 64'd1);
    chk("rst_hold", 64'(wb_hold_o), 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count_o), 64'd0);
    chk("rst_pending", 64'(dut.pending_q), 64'd0);

    // Issue rd=5, stall decode until the result retires.
    tick(); mc_issue_i = 1; mc_issue_rd_i = 5;
    tick(); idle(); dec_rs1_addr_i = 5; #1;
    chk("raw_stall_a", 64'(dec_stall_o), 64'd1);
    tick(); #1;
    chk("raw_stall_b", 64'(dec_stall_o), 64'd1);
    tick(); mc(5'd5, 32'hDEADBEEF); #1;
    chk("raw_accept_ready", 64'(mc_ready_o), 64'd1);
    chk("raw_no_bypass", 64'(rf_we_o), 64'd0);
    chk("raw_stall_c", 64'(dec_stall_o), 64'd1);
    tick(); mc_valid_i = 0; #1;
    chk_port("raw_write", 1, 5'd5, 32'hDEADBEEF);
    chk("raw_stall_drop", 64'(dec_stall_o), 64'd0);
    tick(); #1;
    chk("raw_pending_clr", 64'(dut.pending_q), 64'd0);
    chk("raw_idle_we", 64'(rf_we_o), 64'd0);

    // Starvation: WB hogs the port every cycle.
    tick(); idle(); wb(5'd6, 32'h66); mc(5'd8, 32'h11); #1;
    chk_port("stv_c0", 1, 5'd6, 32'h66);
    tick(); mc(5'd9, 32'h22); #1;
    chk("stv_c1_ready", 64'(mc_ready_o), 64'd1);
    chk_port("stv_c1", 1, 5'd6, 32'h66);
    tick(); mc(5'd10, 32'h33); #1;
    chk("stv_c2_ready", 64'(mc_ready_o), 64'd0);
    chk("stv_c2_hold", 64'(wb_hold_o), 64'd0);
    tick(); #1;
    chk("stv_c3_hold", 64'(wb_hold_o), 64'd0);
    tick(); #1;
    chk("stv_c4_hold", 64'(wb_hold_o), 64'd0);
    chk_port("stv_c4", 1, 5'd6, 32'h66);
    tick(); wb_we_i = 0; #1;
    chk("stv_c5_hold", 64'(wb_hold_o), 64'd1);
    chk("stv_c5_ready", 64'(mc_ready_o), 64'd0);
    chk_port("stv_c5_head", 1, 5'd8, 32'h11);
    tick(); wb(5'd6, 32'h66); #1;
    chk("stv_c6_hold", 64'(wb_hold_o), 64'd0);
    chk("stv_c6_ready", 64'(mc_ready_o), 64'd1);
    tick(); idle(); #1;
    chk_port("stv_drain_a", 1, 5'd9, 32'h22);
    tick(); #1;
    chk_port("stv_drain_b", 1, 5'd10, 32'h33);
    tick(); #1;
    chk("stv_drained", 64'(rf_we_o), 64'd0);

    // Push and pop in the same cycle with one entry queued.
    wb(5'd6, 32'h66); mc(5'd11, 32'h1);
    tick(); idle(); mc(5'd12, 32'h2); #1;
    chk_port("pp_first", 1, 5'd11, 32'h1);
    tick(); idle(); #1;
    chk("pp_count", 64'(dut.u_fifo.count_o), 64'd1);
    chk_port("pp_second", 1, 5'd12, 32'h2);
    tick(); #1;
    chk("pp_empty", 64'(dut.u_fifo.count_o), 64'd0);

    // Result to x0 is popped but never written.
    mc(5'd0, 32'h55);
    tick(); idle(); #1;
    chk("x0_result_we", 64'(rf_we_o), 64'd0);
    tick(); #1;
    chk("x0_result_popped", 64'(dut.u_fifo.count_o), 64'd0);
    chk("x0_result_pending", 64'(dut.pending_q), 64'd0);
    wb(5'd0, 32'h99); mc(5'd13, 32'h77); #1;
    chk("x0_wb_we", 64'(rf_we_o), 64'd0);
    tick(); mc_valid_i = 0; #1;
    chk_port("x0_wb_loses", 1, 5'd13, 32'h77);

    // Reissue of rd=7 in the same cycle its older result retires.
    tick(); idle(); mc_issue_i = 1; mc_issue_rd_i = 7;
    tick(); idle(); wb(5'd6, 32'h66); mc(5'd7, 32'hA);
    tick(); idle(); mc_issue_i = 1; mc_issue_rd_i = 7; #1;
    chk_port("reissue_pop", 1, 5'd7, 32'hA);
    tick(); idle(); dec_rs2_addr_i = 7; wb(5'd6, 32'h66); mc(5'd20, 32'h1); #1;
    chk("reissue_pending", 64'(dut.pending_q), 64'h80);
    chk("reissue_stall", 64'(dec_stall_o), 64'd1);
    tick(); mc(5'd21, 32'h2);
    tick(); mc_valid_i = 0; #1;
    chk("full_ready", 64'(mc_ready_o), 64'd0);
    chk("full_count", 64'(dut.u_fifo.count_o), 64'd2);

    // Reset mid-operation.
    rst_i = 1; #1;
    chk("midrst_rf_we", 64'(rf_we_o), 64'd0);
    chk("midrst_stall", 64'(dec_stall_o), 64'd0);
    tick(); #1;
    chk("midrst_count", 64'(dut.u_fifo.count_o), 64'd0);
    chk("midrst_pending", 64'(dut.pending_q), 64'd0);
    chk("midrst_ready", 64'(mc_ready_o), 64'd1);
    rst_i = 0; wb_we_i = 0; #1;
    chk("postrst_rf_we", 64'(rf_we_o), 64'd0);
    chk("postrst_stall", 64'(dec_stall_o), 64'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
